// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the pipeline phase sequencer: phase indices, default
// phase count, state encodings and the phase-index width helper.
package phase_pkg;

    localparam int PH_IF  = 0;
    localparam int PH_ID  = 1;
    localparam int PH_EX  = 2;
    localparam int PH_MEM = 3;
    localparam int PH_WB  = 4;

    localparam int NUM_PHASES_DEF = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Width of a binary phase index, never below one bit.
    function automatic int phase_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control-unit <-> sequencer bundle; the master side is the core control unit,
// the slave side is the sequencer itself.
interface phase_sequencer_if
    import phase_pkg::*;
#(
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int CNT_W      = 32
);
    localparam int PHASE_W = phase_w(NUM_PHASES);

    logic                  run;
    logic                  stall;
    logic [NUM_PHASES-1:0] skip_mask;
    logic [NUM_PHASES-1:0] phase_en;
    logic [PHASE_W-1:0]    phase_idx;
    logic                  busy;
    logic                  instr_done;
    logic [CNT_W-1:0]      instr_count;

    modport master (
        output run, stall, skip_mask,
        input  phase_en, phase_idx, busy, instr_done, instr_count
    );

    modport slave (
        input  run, stall, skip_mask,
        output phase_en, phase_idx, busy, instr_done, instr_count
    );

endinterface

// File: rtl/phase_sequencer_next_sel.sv
// Priority search for the lowest non-skipped phase above the current one;
// o_wrap flags that the instruction has no later phase.
module phase_next_sel #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3
) (
    input  logic [PHASE_W-1:0]    i_cur_idx,
    input  logic [NUM_PHASES-1:0] i_skip,
    output logic [PHASE_W-1:0]    o_next_idx,
    output logic                  o_wrap
);

    always_comb begin
        o_next_idx = '0;
        o_wrap     = 1'b1;
        for (int unsigned j = 0; j < NUM_PHASES; j++) begin
            if (o_wrap && (PHASE_W'(j) > i_cur_idx) && !i_skip[j]) begin
                o_next_idx = PHASE_W'(j);
                o_wrap     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle pipeline phase sequencer: one-hot stage enables with phase
// skipping, stall hold, boundary-clean halt and a retired-instruction counter.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    phase_sequencer_if.slave  seq
);

    localparam int PHASE_W = phase_w(NUM_PHASES);

    logic [0:0]            r_state;
    logic [NUM_PHASES-1:0] r_phase_en;
    logic [PHASE_W-1:0]    r_phase_idx;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_PHASES-1:0] r_skip;

    logic [NUM_PHASES-1:0] w_eff_skip;
    logic [PHASE_W-1:0]    w_next_idx;
    logic                  w_wrap;

    // Phase 0 decides the instruction's skip set from the live mask; later
    // phases use the copy latched when phase 0 was left.
    assign w_eff_skip = (r_phase_idx == '0) ? seq.skip_mask : r_skip;

    phase_next_sel #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W)
    ) u_next_sel (
        .i_cur_idx  (r_phase_idx),
        .i_skip     (w_eff_skip),
        .o_next_idx (w_next_idx),
        .o_wrap     (w_wrap)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= ST_IDLE;
            r_phase_en  <= '0;
            r_phase_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_skip      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (seq.run) begin
                        r_state     <= ST_RUN;
                        r_phase_en  <= NUM_PHASES'(1);
                        r_phase_idx <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    if (!seq.stall) begin
                        if (r_phase_idx == '0) begin
                            r_skip <= seq.skip_mask;
                        end
                        if (w_wrap) begin
                            r_done      <= 1'b1;
                            r_count     <= r_count + CNT_W'(1);
                            r_phase_idx <= '0;
                            if (seq.run) begin
                                r_phase_en <= NUM_PHASES'(1);
                            end else begin
                                r_state    <= ST_IDLE;
                                r_phase_en <= '0;
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            r_phase_en  <= NUM_PHASES'(1) << w_next_idx;
                            r_phase_idx <= w_next_idx;
                        end
                    end
                end
            endcase
        end
    end

    assign seq.phase_en    = r_phase_en;
    assign seq.phase_idx   = r_phase_idx;
    assign seq.busy        = r_busy;
    assign seq.instr_done  = r_done;
    assign seq.instr_count = r_count;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-cycle phase sequencer that drives the processor's pipeline-stage enables (IF, ID, EX, MEM, WB, …) as a one-hot level vector. It is the successor to the fixed 4-phase ring generator and adds a configurable phase count, per-instruction phase skipping, stall hold, run/halt control with clean instruction-boundary stop, and a retired-instruction counter. It sits between the core's control unit and every stage register bank.

## Interface

Parameters:
- `NUM_PHASES`, default 5: number of phases. Legal range is 2..16. Index 0 is IF and is never skipped.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: the single clock.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: enable sequencing. When it is low, the sequencer halts at the next instruction boundary.
- `stall`, in, 1: hold the current phase.
- `skip_mask`, in, NUM_PHASES: a 1 in bit k bypasses phase k for the current instruction. Bit 0 is ignored.
- `phase_en`, out, NUM_PHASES: one-hot active phase. It is all-zero when idle.
- `phase_idx`, out, PHASE_W = max(1, clog2(NUM_PHASES)): binary index of the active phase. It is 0 when idle.
- `busy`, out, 1: high while any phase is active.
- `instr_done`, out, 1: one-cycle pulse after the last active phase of an instruction completes.
- `instr_count`, out, CNT_W: number of retired instructions. It wraps modulo 2^CNT_W.

## Operation

- There are two states: IDLE and RUN. All outputs are registered.
- Reset, asynchronous and taking effect immediately:
  - state = IDLE
  - phase_en = 0, phase_idx = 0, busy = 0, instr_done = 0, instr_count = 0
  - skip latch = 0
- IDLE:
  - If `run`=1 at an edge, go to RUN with phase 0 active.
  - `stall` and `skip_mask` are ignored.
- RUN, with `stall`=1: the current phase is held and `phase_en` stays asserted. No other register changes.
- RUN, with `stall`=0, the sequencer advances. Next phase is the lowest j > current with skip bit j = 0.
  - Leaving phase 0: the skip bits come from live `skip_mask`. The same edge latches `skip_mask` into the skip latch.
  - Leaving any other phase: the skip bits come from the skip latch. Mid-instruction changes to `skip_mask` therefore have no effect.
- No such j exists (instruction complete):
  - Pulse `instr_done` and increment `instr_count`.
  - If `run`=1, go to phase 0.
  - If `run`=0, go to IDLE.
- `run` deasserted mid-instruction does not abort. The instruction finishes all its remaining non-skipped phases first.
- If `skip_mask` bits 1..NUM_PHASES-1 are all 1, the instruction is phase 0 only. It completes on its first unstalled cycle.
- A stall on the final phase delays `instr_done` until the stall is released.
- `phase_idx` always equals the encoded `phase_en` when busy.

## Timing

- Start latency: `run` sampled high in IDLE gives phase 0 active in the next cycle.
- An instruction with no stalls and m non-skipped phases occupies exactly m cycles.
- Back-to-back instructions: the next phase 0 follows the last phase with no gap cycle.
- `instr_done` and the `instr_count` update are in the same cycle. That is the cycle after the last phase, coinciding with the new phase 0 or with the first IDLE cycle.
- Halt: after the final phase with `run`=0, the following cycle shows busy = 0 and phase_en = 0.
- Reset asserted mid-instruction: outputs are cleared asynchronously. No `instr_done` is produced for the aborted instruction.

## Structure

- The shared package `phase_pkg` holds:
  - phase index constants PH_IF=0, PH_ID=1, PH_EX=2, PH_MEM=3, PH_WB=4
  - the default NUM_PHASES
  - the state encoding constants ST_IDLE and ST_RUN
- Sub-module `phase_next_sel`:
  - It is a combinational priority search.
  - Inputs: current index and effective skip vector.
  - Outputs: next index and a `wrap` flag meaning no later phase exists.
  - It is parametrised on NUM_PHASES.
- The top level holds the state register, one-hot/index registers, skip latch, done pulse, and counter.

## Test plan

- Reset, then `run`=1 with skip = 0 and NUM_PHASES=5:
  - phase_idx goes 0,1,2,3,4,0.
  - `instr_done` pulses exactly once per 5 cycles.
  - `instr_count` = 3 after 15 run cycles.
- skip_mask = 5'b01100, skipping EX and MEM: the sequence is 0,1,4,0. That is 3 cycles per instruction.
- skip_mask changed to 5'b11110 while in phase 1: the current instruction still follows its latched mask. The next instruction is phase 0 only, with an `instr_done` pulse every cycle.
- `stall`=1 for 3 cycles during phase 2: phase_en = 5'b00100 is held for 4 cycles total, and `instr_done` is delayed by 3 cycles.
- `run` dropped during phase 1: phases 2, 3 and 4 complete, then `instr_done` pulses with busy = 0 in the same cycle. The sequencer stays IDLE until `run`=1.
- `n_reset` asserted mid phase 3: all outputs are 0 immediately. After release with `run`=1, phase 0 starts and `instr_count` restarts from 0.
